mesh_term_src_fifo: RTL and testbench
=====================================

// Module: mesh_term_src_fifo
// PURPOSE
//  Terminal-side source buffer that feeds one external port of the mesh router.
//  Accepts packets from the terminal/driver side and presents them on the mesh
//  pending/data pair (pndng_i_in[k], data_out_i_in[k]). Dequeues when the mesh
//  asserts popin[k]. One instance per port; ROWS*2+COLUMS*2 instances per mesh.
// PARAMETERS
//  PCKG_SZ  40  packet width in bits (same value as the mesh)
//  DEPTH    8   FIFO entries; any value >= 2 (power of two not required)
//  PORT_ID  0   port index, used only in assertion/stat messages
// PORTS
//  clk            in   1         clock, all state on rising edge
//  reset          in   1         asynchronous, active-low reset (reset==0 clears state)
//  push           in   1         terminal writes data_in this cycle
//  data_in        in   PCKG_SZ   packet to enqueue
//  full           out  1         FIFO holds DEPTH entries
//  popin          in   1         mesh consumes head packet this cycle
//  pndng_i_in     out  1         head packet valid toward mesh
//  data_out_i_in  out  PCKG_SZ   head packet toward mesh
//  count          out  $clog2(DEPTH+1)  current occupancy
//  overflow       out  1         sticky: push dropped while full
//  underflow      out  1         sticky: popin seen while empty
// BEHAVIOUR
//  - Reset (async assert, sync release): count=0, rd/wr ptr=0, full=0,
//    pndng_i_in=0, data_out_i_in=0, overflow=0, underflow=0. Storage not cleared.
//    Reset mid-transfer discards all queued packets immediately.
//  - Show-ahead FIFO. data_out_i_in = mem[rd_ptr] when count>0, else all zeros.
//    pndng_i_in = (count!=0). Both are derived from registered state only, never from
//    push/data_in in the same cycle.
//  - Latency: push sampled at edge N -> pndng_i_in=1 and data visible after edge N.
//    No empty bypass.
//  - popin sampled at edge N with count>0 -> rd_ptr advances; next head visible after N.
//  - State (derived from count): EMPTY(0) -> ACTIVE(1..DEPTH-1) -> FULL(DEPTH).
//    EMPTY+push -> ACTIVE (or FULL if DEPTH==1, not allowed).
//    ACTIVE+push only -> count+1. ACTIVE+pop only -> count-1. Both -> count unchanged.
//  - Simultaneous events:
//    FULL+push+popin: both accepted, count stays DEPTH, no overflow.
//    FULL+push without popin: data dropped, overflow<=1, pointers unchanged.
//    EMPTY+popin: ignored, underflow<=1. EMPTY+push+popin: push accepted, pop ignored,
//    underflow<=1.
//  - Pointer wrap: ptr==DEPTH-1 -> 0 on increment (explicit compare, no modulo-2^n).
//  - count arithmetic is unsigned, width $clog2(DEPTH+1); it never exceeds DEPTH.
//    full = (count==DEPTH).
// CONFIGURATION
//  MESH_TERM_FIFO_STATS_EN defined: adds outputs push_cnt, pop_cnt, drop_cnt
//    (32-bit each, reset 0, saturating at 2^32-1). They count accepted pushes,
//    accepted pops and dropped pushes.
//  Undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  mesh_pkg: PCKG_SZ default, typedef logic [PCKG_SZ-1:0] pkt_t, N_PORTS(ROWS,COLUMS)
//    function = ROWS*2+COLUMS*2. Shared with the mesh interface and testbench.
//  Sub-module: mesh_fifo_mem (DEPTH x PCKG_SZ register array, 1 write/1 async read
//    port, no reset). Control, pointers and flags stay in mesh_term_src_fifo.
// TESTING (DEPTH=4, PCKG_SZ=40)
//  1. Reset, push 40'hA5_0000_0001 -> next cycle pndng_i_in=1, data_out_i_in=40'hA5_0000_0001,
//     count=1.
//  2. Push 4 packets 1..4, then a 5th (5) without popin -> full=1, overflow=1, count=4;
//     pop 4x yields 1,2,3,4, then pndng_i_in=0.
//  3. Full FIFO, push 9 + popin same cycle -> count stays 4, overflow=0; drain order
//     2,3,4,9.
//  4. Empty FIFO, popin=1 -> underflow=1, count=0; push+popin together on empty ->
//     count=1, head=pushed packet.
//  5. Push/pop streaming 10 packets with DEPTH=4 -> pointers wrap twice, order preserved,
//     no flags set.
//  6. Reset low asynchronously (mid-clock) with count=3 -> outputs zero immediately.
//     After release, count=0 and old data never appears. With STATS_EN, scenario 2
//     gives push_cnt=4, drop_cnt=1.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared mesh definitions: default packet width, packet type, FIFO occupancy
// states and the port-count helper used by the mesh, its terminals and benches.
package mesh_pkg;

    localparam int unsigned DefaultPckgSz = 40;

    typedef logic [DefaultPckgSz-1:0] pkt_t;

    // Occupancy class of a terminal FIFO, derived from its count.
    typedef enum logic [1:0] {
        StEmpty  = 2'd0,
        StActive = 2'd1,
        StFull   = 2'd2
    } fifo_state_e;

    // Number of external ports on a ROWS x COLUMS mesh.
    function automatic int unsigned N_PORTS(input int unsigned rows, input int unsigned colums);
        return rows * 2 + colums * 2;
    endfunction

endpackage

// File: rtl/mesh_fifo_mem.sv
// Storage array for the terminal FIFO: Depth x Width registers, one write port
// and one asynchronous read port. Deliberately unreset; validity is tracked by
// the controller's occupancy count.
module mesh_fifo_mem #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 40,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mesh_term_src_fifo.sv
// Terminal-side source FIFO feeding one external mesh port. Show-ahead: the
// head packet and its pending flag come from registered state only, so a push
// becomes visible the cycle after it is sampled (no empty bypass).
// Optional build macro MESH_TERM_FIFO_STATS_EN adds saturating 32-bit
// push/pop/drop counters as extra outputs.
module mesh_term_src_fifo
    import mesh_pkg::*;
#(
    parameter int unsigned PCKG_SZ = DefaultPckgSz,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PORT_ID = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [PCKG_SZ-1:0]           data_in,
    output logic                         full,
    input  logic                         popin,
    output logic                         pndng_i_in,
    output logic [PCKG_SZ-1:0]           data_out_i_in,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
`ifdef MESH_TERM_FIFO_STATS_EN
    ,
    output logic [31:0]                  push_cnt,
    output logic [31:0]                  pop_cnt,
    output logic [31:0]                  drop_cnt
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               do_push, do_pop;
    logic [PCKG_SZ-1:0] mem_rdata;
    fifo_state_e        state;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PtrW'(1);
    endfunction

    // Classify occupancy from the registered count.
    always_comb begin
        state = StActive;
        if (count_q == '0) begin
            state = StEmpty;
        end else if (count_q == CntW'(DEPTH)) begin
            state = StFull;
        end
    end

    // Decide which requests are accepted and compute next pointers, count and flags.
    always_comb begin
        do_push     = 1'b0;
        do_pop      = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        unique case (state)
            StEmpty: begin
                do_push = push;
                if (popin) begin
                    underflow_d = 1'b1;
                end
            end
            StActive: begin
                do_push = push;
                do_pop  = popin;
            end
            StFull: begin
                // A push into a full FIFO only fits if the head leaves this cycle.
                do_pop  = popin;
                do_push = push & popin;
                if (push && !popin) begin
                    overflow_d = 1'b1;
                end
            end
            default: ;
        endcase

        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    // Control state register; reset discards all queued packets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    mesh_fifo_mem #(
        .Depth (DEPTH),
        .Width (PCKG_SZ),
        .AddrW (PtrW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (do_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign count         = count_q;
    assign full          = (state == StFull);
    assign pndng_i_in    = (state != StEmpty);
    // Zero the head when empty so stale storage never leaks toward the mesh.
    assign data_out_i_in = pndng_i_in ? mem_rdata : '0;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

`ifdef MESH_TERM_FIFO_STATS_EN
    logic [31:0] push_cnt_q, pop_cnt_q, drop_cnt_q;
    logic        drop_evt;

    assign drop_evt = (state == StFull) && push && !popin;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (do_push && (push_cnt_q != '1)) begin
                push_cnt_q <= push_cnt_q + 32'd1;
            end
            if (do_pop && (pop_cnt_q != '1)) begin
                pop_cnt_q <= pop_cnt_q + 32'd1;
            end
            if (drop_evt && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign push_cnt = push_cnt_q;
    assign pop_cnt  = pop_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

    // Occupancy must stay within the configured depth.
    count_bound_a: assert property (@(posedge clk) disable iff (!reset)
        count_q <= CntW'(DEPTH))
        else $error("mesh_term_src_fifo port %0d: count exceeds depth", PORT_ID);

endmodule

// File: tb/tb_mesh_term_src_fifo.sv
// Directed self-checking bench for mesh_term_src_fifo at DEPTH=4, PCKG_SZ=40.
module tb_mesh_term_src_fifo;
    import mesh_pkg::*;

    localparam int unsigned Depth = 4;

    logic       clk;
    logic       reset;
    logic       push;
    pkt_t       data_in;
    logic       full;
    logic       popin;
    logic       pndng;
    pkt_t       data_out;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;
`ifdef MESH_TERM_FIFO_STATS_EN
    logic [31:0] push_cnt, pop_cnt, drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mesh_term_src_fifo #(
        .PCKG_SZ (40),
        .DEPTH   (Depth),
        .PORT_ID (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .data_in       (data_in),
        .full          (full),
        .popin         (popin),
        .pndng_i_in    (pndng),
        .data_out_i_in (data_out),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
`ifdef MESH_TERM_FIFO_STATS_EN
        ,
        .push_cnt      (push_cnt),
        .pop_cnt       (pop_cnt),
        .drop_cnt      (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push    = 1'b0;
        popin   = 1'b0;
        data_in = '0;
        reset   = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic push_one(input pkt_t d);
        push    = 1'b1;
        data_in = d;
        step();
        push = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input pkt_t d);
        check_eq(tag, {24'd0, data_out}, {24'd0, d});
        popin = 1'b1;
        step();
        popin = 1'b0;
    endtask

    initial begin
        // 1: reset state and first-push latency
        do_reset();
        check_eq("rst_count", {61'd0, count}, 64'd0);
        check_eq("rst_pndng", {63'd0, pndng}, 64'd0);
        check_eq("rst_data", {24'd0, data_out}, 64'd0);
        check_eq("rst_full", {63'd0, full}, 64'd0);
        check_eq("rst_flags", {62'd0, overflow, underflow}, 64'd0);
        push = 1'b1;
        data_in = 40'hA5_0000_0001;
        #2;
        // pushed data must not bypass to the output before the edge
        check_eq("no_bypass", {63'd0, pndng}, 64'd0);
        step();
        push = 1'b0;
        check_eq("s1_pndng", {63'd0, pndng}, 64'd1);
        check_eq("s1_data", {24'd0, data_out}, 64'h00_0000_A5_0000_0001);
        check_eq("s1_count", {61'd0, count}, 64'd1);

        // 2: fill, overflow on a 5th push, drain in order
        do_reset();
        for (int i = 1; i <= 4; i++) push_one(pkt_t'(i));
        check_eq("s2_full4", {63'd0, full}, 64'd1);
        push_one(pkt_t'(5));
        check_eq("s2_full", {63'd0, full}, 64'd1);
        check_eq("s2_ovf", {63'd0, overflow}, 64'd1);
        check_eq("s2_count", {61'd0, count}, 64'd4);
`ifdef MESH_TERM_FIFO_STATS_EN
        check_eq("s2_push_cnt", {32'd0, push_cnt}, 64'd4);
        check_eq("s2_drop_cnt", {32'd0, drop_cnt}, 64'd1);
`endif
        for (int i = 1; i <= 4; i++) pop_expect("s2_head", pkt_t'(i));
        check_eq("s2_empty_pndng", {63'd0, pndng}, 64'd0);
        check_eq("s2_empty_data", {24'd0, data_out}, 64'd0);
        check_eq("s2_unf", {63'd0, underflow}, 64'd0);

        // 3: push and pop on a full FIFO are both accepted
        do_reset();
        for (int i = 1; i <= 4; i++) push_one(pkt_t'(i));
        push    = 1'b1;
        popin   = 1'b1;
        data_in = pkt_t'(9);
        step();
        push  = 1'b0;
        popin = 1'b0;
        check_eq("s3_count", {61'd0, count}, 64'd4);
        check_eq("s3_ovf", {63'd0, overflow}, 64'd0);
        pop_expect("s3_head2", pkt_t'(2));
        pop_expect("s3_head3", pkt_t'(3));
        pop_expect("s3_head4", pkt_t'(4));
        pop_expect("s3_head9", pkt_t'(9));
        check_eq("s3_count_end", {61'd0, count}, 64'd0);

        // 4: pop on empty, then push+pop on empty
        do_reset();
        popin = 1'b1;
        step();
        popin = 1'b0;
        check_eq("s4_unf", {63'd0, underflow}, 64'd1);
        check_eq("s4_count0", {61'd0, count}, 64'd0);
        push    = 1'b1;
        popin   = 1'b1;
        data_in = 40'h77_1234_5678;
        step();
        push  = 1'b0;
        popin = 1'b0;
        check_eq("s4_count1", {61'd0, count}, 64'd1);
        check_eq("s4_head", {24'd0, data_out}, 64'h77_1234_5678);

        // 5: streaming 10 packets wraps both pointers twice
        do_reset();
        push_one(pkt_t'(100));
        for (int i = 1; i < 10; i++) begin
            check_eq("s5_head", {24'd0, data_out}, 64'(100 + i - 1));
            push    = 1'b1;
            popin   = 1'b1;
            data_in = pkt_t'(100 + i);
            step();
        end
        push  = 1'b0;
        popin = 1'b0;
        check_eq("s5_count", {61'd0, count}, 64'd1);
        pop_expect("s5_last", pkt_t'(109));
        check_eq("s5_flags", {62'd0, overflow, underflow}, 64'd0);

        // 6: asynchronous reset mid-cycle with three packets queued
        do_reset();
        push_one(40'hD1);
        push_one(40'hD2);
        push_one(40'hD3);
        check_eq("s6_count3", {61'd0, count}, 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check_eq("s6_async_count", {61'd0, count}, 64'd0);
        check_eq("s6_async_pndng", {63'd0, pndng}, 64'd0);
        check_eq("s6_async_data", {24'd0, data_out}, 64'd0);
        step();
        reset = 1'b1;
        step();
        check_eq("s6_post_count", {61'd0, count}, 64'd0);
        check_eq("s6_post_data", {24'd0, data_out}, 64'd0);
        push_one(40'hEE);
        check_eq("s6_new_head", {24'd0, data_out}, 64'hEE);
        check_eq("s6_new_count", {61'd0, count}, 64'd1);
        pop_expect("s6_pop", 40'hEE);
        check_eq("s6_end_pndng", {63'd0, pndng}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
